// File: rtl/camera_config_sequencer.sv
// Walks the OV7670 configuration ROM at power-up and feeds one SCCB register
// write per entry, honouring delay (FF_F0) and end (FF_FF) markers.
module camera_config_sequencer #(
  parameter int DELAY_CYCLES = 240000,
  parameter int MAX_RETRIES  = 3,
  parameter bit AUTO_START   = 1'b1
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  output logic [7:0]  o_rom_addr,
  input  logic [15:0] i_rom_dout,
  output logic        o_wr_valid,
  input  logic        i_wr_ready,
  output logic [7:0]  o_wr_reg,
  output logic [7:0]  o_wr_data,
  input  logic        i_wr_done,
  input  logic        i_wr_nack,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_error,
  output logic [7:0]  o_err_addr,
  output logic [7:0]  o_wr_count
);

  localparam logic [3:0] S_IDLE       = 4'd0;
  localparam logic [3:0] S_FETCH      = 4'd1;
  localparam logic [3:0] S_LATCH      = 4'd2;
  localparam logic [3:0] S_DECODE     = 4'd3;
  localparam logic [3:0] S_WRITE_REQ  = 4'd4;
  localparam logic [3:0] S_WRITE_WAIT = 4'd5;
  localparam logic [3:0] S_DELAY      = 4'd6;
  localparam logic [3:0] S_DONE       = 4'd7;
  localparam logic [3:0] S_ERROR      = 4'd8;

  localparam int DW = (DELAY_CYCLES > 1) ? $clog2(DELAY_CYCLES) : 1;
  localparam int RW = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;
  localparam logic [DW-1:0] DELAY_LOAD = DW'(DELAY_CYCLES - 1);
  localparam logic [RW-1:0] RETRY_MAX  = RW'(MAX_RETRIES);

  logic [3:0]    state;
  logic [DW-1:0] delay_cnt;
  logic [RW-1:0] retry_cnt;
  logic          auto_pending;
  logic          start_ok;
  logic          advance;

  // A start is honoured only from the resting states; auto_pending stands in
  // for i_start on the first cycle after reset when AUTO_START is set.
  assign start_ok = ((state == S_IDLE) && (i_start || auto_pending)) ||
                    (((state == S_DONE) || (state == S_ERROR)) && i_start);

  assign advance = ((state == S_WRITE_WAIT) && i_wr_done && !i_wr_nack) ||
                   ((state == S_DELAY) && (delay_cnt == '0));

  assign o_wr_valid = (state == S_WRITE_REQ);
  assign o_busy     = (state != S_IDLE) && (state != S_DONE) && (state != S_ERROR);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state        <= S_IDLE;
      delay_cnt    <= '0;
      retry_cnt    <= '0;
      auto_pending <= AUTO_START;
      o_rom_addr   <= 8'd0;
      o_wr_reg     <= 8'd0;
      o_wr_data    <= 8'd0;
      o_done       <= 1'b0;
      o_error      <= 1'b0;
      o_err_addr   <= 8'd0;
      o_wr_count   <= 8'd0;
    end else if (start_ok) begin
      state        <= S_FETCH;
      auto_pending <= 1'b0;
      o_rom_addr   <= 8'd0;
      o_wr_count   <= 8'd0;
      o_done       <= 1'b0;
      o_error      <= 1'b0;
      o_err_addr   <= 8'd0;
    end else if (advance) begin
      if ((state == S_WRITE_WAIT) && (o_wr_count != 8'hFF)) begin
        o_wr_count <= o_wr_count + 8'd1;
      end
      // The last ROM address terminates the run even without an end marker.
      if (o_rom_addr == 8'hFF) begin
        state  <= S_DONE;
        o_done <= 1'b1;
      end else begin
        o_rom_addr <= o_rom_addr + 8'd1;
        state      <= S_FETCH;
      end
    end else begin
      case (state)
        S_FETCH: state <= S_LATCH;
        S_LATCH: state <= S_DECODE;
        S_DECODE: begin
          if (i_rom_dout == 16'hFFFF) begin
            state  <= S_DONE;
            o_done <= 1'b1;
          end else if (i_rom_dout == 16'hFFF0) begin
            state     <= S_DELAY;
            delay_cnt <= DELAY_LOAD;
          end else begin
            state     <= S_WRITE_REQ;
            o_wr_reg  <= i_rom_dout[15:8];
            o_wr_data <= i_rom_dout[7:0];
            retry_cnt <= '0;
          end
        end
        S_WRITE_REQ: begin
          if (i_wr_ready) state <= S_WRITE_WAIT;
        end
        S_WRITE_WAIT: begin
          if (i_wr_done && i_wr_nack) begin
            if (retry_cnt < RETRY_MAX) begin
              retry_cnt <= retry_cnt + 1'b1;
              state     <= S_WRITE_REQ;
            end else begin
              state      <= S_ERROR;
              o_error    <= 1'b1;
              o_err_addr <= o_rom_addr;
            end
          end
        end
        S_DELAY: delay_cnt <= delay_cnt - 1'b1;
        S_IDLE, S_DONE, S_ERROR: ;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
